timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Brief    : Memory-mapped down-counting timer (CTRL/PRESET/COUNT) with a
//            one-shot or auto-reload interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_CNT  = 2'd2;
    localparam logic [1:0] c_INT  = 2'd3;

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_PRESET = 2'd1;
    localparam logic [1:0] c_REG_COUNT  = 2'd2;

    localparam logic [1:0] c_MODE_RELOAD = 2'd1;

    logic [1:0]  r_state;
    logic [3:0]  r_ctrl;     // {IM, MODE[1:0], EN}
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;

    logic [1:0]  w_sel;
    logic        w_hit;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_unused_addr;

    assign w_sel         = addr[3:2];
    assign w_hit         = (addr[31:4] == BASE[31:4]) && (w_sel != 2'b11);
    assign w_wr_ctrl     = w_hit && (byteen != 4'b0000) && (w_sel == c_REG_CTRL);
    assign w_wr_preset   = w_hit && (byteen != 4'b0000) && (w_sel == c_REG_PRESET);
    assign w_unused_addr = ^addr[1:0];

    assign hit = w_hit;
    assign irq = r_ctrl[3] & r_flag;

    always_comb begin
        rdata = 32'd0;
        if (w_hit) begin
            case (w_sel)
                c_REG_CTRL:   rdata = {28'd0, r_ctrl};
                c_REG_PRESET: rdata = r_preset;
                c_REG_COUNT:  rdata = r_count;
                default:      rdata = 32'd0;
            endcase
        end
    end

    // Bus writes are placed after the FSM so their assignments take priority
    // (a CTRL/PRESET write clears FLAG even on the INT-entry edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_ctrl   <= 4'd0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_ctrl[0]) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_count <= r_preset;
                    r_state <= c_CNT;
                end
                c_CNT: begin
                    if (!r_ctrl[0]) begin
                        r_state <= c_IDLE;
                    end else if (r_count == 32'd0) begin
                        r_state <= c_INT;
                        r_flag  <= 1'b1;
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                c_INT: begin
                    if (r_ctrl[2:1] == c_MODE_RELOAD) begin
                        r_state <= c_LOAD;
                        r_flag  <= 1'b0;
                    end else begin
                        r_ctrl[0] <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_wr_ctrl) begin
                r_flag <= 1'b0;
                if (byteen[0]) begin
                    r_ctrl <= wdata[3:0];
                end
            end

            if (w_wr_preset) begin
                r_flag <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (byteen[i]) begin
                        r_preset[8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
